// File: rtl/fir_cap_pkg.sv
// fir_cap_pkg: shared types for the FIR sample capture block.
package fir_cap_pkg;

  localparam int CAP_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } cap_state_t;

  typedef logic signed [CAP_DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_cap_ram.sv
// fir_cap_ram: simple dual-port capture buffer, one write port and one
// synchronous read port. The array is never reset; the read register holds
// its value while re is low so the readout pipeline can stall on it.
module fir_cap_ram
  import fir_cap_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_sample_capture.sv
// fir_sample_capture: single-shot capture buffer at the FIR output, drained
// in capture order over a valid/ready readout port.
// Optional build macro CAP_PEAK_DETECT_EN adds the peak magnitude tracker
// and its peak port.
//
// state | meaning
// IDLE  | waiting for arm; count/overrun of the last run stay visible
// SKIP  | discarding PRE_SKIP samples of filter fill latency
// FILL  | writing valid samples into the buffer
// DRAIN | streaming captured samples out, oldest first
module fir_sample_capture
  import fir_cap_pkg::*;
#(
  parameter int DATA_W   = CAP_DATA_W,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int PRE_SKIP = 0
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     arm,
  input  logic                     stop,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic                     y_valid,
  output logic        [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     done,
  output logic        [ADDR_W:0]   count,
  output logic                     overrun
`ifdef CAP_PEAK_DETECT_EN
  ,
  output logic        [DATA_W-1:0] peak
`endif
);

  localparam logic [7:0]    SKIP_LAST = 8'((PRE_SKIP > 0) ? PRE_SKIP - 1 : 0);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

  cap_state_t        state;
  logic [7:0]        skip_cnt;
  logic [ADDR_W:0]   rd_ptr;
  logic              q_vld;
  logic              q_last;
  logic [DATA_W-1:0] ram_q;
  logic              wr_en;
  logic              out_free;
  logic              q_adv;
  logic              rd_issue;
  logic              last_acc;

  // buffer is never wrapped, so the sample count doubles as write pointer
  always_comb begin
    wr_en    = 1'b0;
    out_free = 1'b0;
    q_adv    = 1'b0;
    rd_issue = 1'b0;
    last_acc = 1'b0;
    wr_en    = (state == FILL) && y_valid;
    out_free = !rd_valid || rd_ready;
    q_adv    = !q_vld || out_free;
    rd_issue = (state == DRAIN) && q_adv && (rd_ptr != count);
    last_acc = rd_valid && rd_ready && rd_last;
  end

  fir_cap_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count[ADDR_W-1:0]),
    .wdata (y_in),
    .re    (rd_issue),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

`ifdef CAP_PEAK_DETECT_EN
  logic [DATA_W-1:0] y_mag;

  // magnitude of the incoming sample; the most negative code clamps to max positive
  always_comb begin
    y_mag = '0;
    if (y_in == {1'b1, {(DATA_W-1){1'b0}}}) y_mag = {1'b0, {(DATA_W-1){1'b1}}};
    else if (y_in[DATA_W-1])                 y_mag = -y_in;
    else                                     y_mag = y_in;
  end
`endif

  assign busy = (state != IDLE);

  // capture FSM, counters and the readout pipeline (RAM read stage + output register)
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      skip_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      q_vld    <= 1'b0;
      q_last   <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
`ifdef CAP_PEAK_DETECT_EN
      peak     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            count    <= '0;
            overrun  <= 1'b0;
            rd_ptr   <= '0;
            skip_cnt <= '0;
            q_vld    <= 1'b0;
            q_last   <= 1'b0;
`ifdef CAP_PEAK_DETECT_EN
            peak     <= '0;
`endif
            state    <= (PRE_SKIP > 0) ? SKIP : FILL;
          end
        end
        SKIP: begin
          if (stop) begin
            state <= IDLE;
          end else if (y_valid) begin
            if (skip_cnt == SKIP_LAST) state <= FILL;
            else                       skip_cnt <= skip_cnt + 8'd1;
          end
        end
        FILL: begin
          if (y_valid) begin
            count <= count + 1'b1;
`ifdef CAP_PEAK_DETECT_EN
            if (y_mag > peak) peak <= y_mag;
`endif
          end
          // a sample arriving with stop is kept, so it counts toward "non-empty"
          if ((y_valid && count == CNT_LAST) || (stop && (y_valid || count != '0)))
            state <= DRAIN;
          else if (stop)
            state <= IDLE;
        end
        DRAIN: begin
          if (y_valid) overrun <= 1'b1;
          if (q_adv) begin
            q_vld  <= rd_issue;
            q_last <= rd_issue && (rd_ptr == count - 1'b1);
            if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
          end
          if (out_free) begin
            rd_valid <= q_vld;
            rd_last  <= q_vld && q_last;
            if (q_vld) rd_data <= ram_q;
          end
          if (last_acc) begin
            state    <= IDLE;
            done     <= 1'b1;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_capture.sv
// tb_fir_sample_capture: two instances (PRE_SKIP=0 and PRE_SKIP=3, DEPTH=8)
// driven by scenario tasks and checked against a sample-list reference model.
module tb_fir_sample_capture;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int N      = 2;

  logic              clk = 1'b0;
  logic              rstN;
  logic              arm      [N];
  logic              stop     [N];
  logic              y_valid  [N];
  logic              rd_ready [N];
  logic [DATA_W-1:0] y_in     [N];
  logic [DATA_W-1:0] rd_data  [N];
  logic              rd_valid [N];
  logic              rd_last  [N];
  logic              busy     [N];
  logic              done     [N];
  logic              overrun  [N];
  logic [ADDR_W:0]   count    [N];
`ifdef CAP_PEAK_DETECT_EN
  logic [DATA_W-1:0] peak     [N];
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [15:0] stim_y[$];
  bit          stim_v[$];
  bit          stim_s[$];
  bit          arm_noise = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    fir_sample_capture #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .PRE_SKIP ((g == 0) ? 0 : 3)
    ) dut (
      .clk      (clk),
      .rstN     (rstN),
      .arm      (arm[g]),
      .stop     (stop[g]),
      .y_in     (y_in[g]),
      .y_valid  (y_valid[g]),
      .rd_data  (rd_data[g]),
      .rd_valid (rd_valid[g]),
      .rd_ready (rd_ready[g]),
      .rd_last  (rd_last[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .count    (count[g]),
      .overrun  (overrun[g])
`ifdef CAP_PEAK_DETECT_EN
      ,
      .peak     (peak[g])
`endif
    );
  end

`ifdef CAP_PEAK_DETECT_EN
  function automatic logic [15:0] mag(input logic [15:0] v);
    int iv;
    iv = int'($signed(v));
    if (iv < 0) iv = -iv;
    if (iv > 32767) iv = 32767;
    return iv[15:0];
  endfunction
`endif

  // arm, stream the stim lists, then drain and check; rst_beat >= 0 resets mid-drain
  task automatic run_case(input int d, input string name, input int ready_mode,
                          input int extra_v, input int rst_beat);
    logic [15:0] exp_q[$];
    int   sk, seen, beat, cyc;
    bit   full, ovr, fin, to_idle, held, got_done, rdy;
    logic [15:0] hd, pk;
    logic hl;
    sk = (d == 0) ? 0 : 3;
    seen = 0; full = 0; ovr = 0; fin = 0; to_idle = 0; pk = '0;
    rd_ready[d] = 0;
    @(negedge clk); arm[d] = 1;
    @(negedge clk); arm[d] = 0;
    for (int i = 0; i < stim_v.size() && !fin; i++) begin
      y_in[d] = stim_y[i]; y_valid[d] = stim_v[i]; stop[d] = stim_s[i];
      arm[d] = arm_noise && ($urandom_range(0, 1) == 1);
      if (full) begin
        if (stim_v[i]) ovr = 1;
      end else if (seen < sk) begin
        if (stim_s[i]) begin fin = 1; to_idle = 1; end
        else if (stim_v[i]) seen++;
      end else begin
        if (stim_v[i]) begin
          exp_q.push_back(stim_y[i]);
`ifdef CAP_PEAK_DETECT_EN
          if (mag(stim_y[i]) > pk) pk = mag(stim_y[i]);
`endif
          seen++;
          if (exp_q.size() == DEPTH) full = 1;
        end
        if (stim_s[i] && !full) begin fin = 1; to_idle = (exp_q.size() == 0); end
        else if (stim_s[i]) fin = 1;
      end
      @(negedge clk);
    end
    arm[d] = 0; stop[d] = 0;
    for (int i = 0; i < extra_v; i++) begin
      y_valid[d] = 1; y_in[d] = 16'($urandom);
      if (!to_idle) ovr = 1;
      @(negedge clk);
    end
    y_valid[d] = 0;

    if (to_idle) begin
      vec_cnt++;
      if (busy[d] !== 1'b0) begin
        $display("FAIL %s idle_busy: got %0b want 0", name, busy[d]); err_cnt++;
      end
      vec_cnt++;
      if (count[d] !== 4'(exp_q.size()) || overrun[d] !== 1'b0) begin
        $display("FAIL %s idle_count: got count=%0d ovr=%0b want count=%0d ovr=0",
                 name, count[d], overrun[d], exp_q.size()); err_cnt++;
      end
      for (int i = 0; i < 3; i++) begin
        vec_cnt++;
        if (done[d] !== 1'b0 || rd_valid[d] !== 1'b0) begin
          $display("FAIL %s idle_no_done: got done=%0b rd_valid=%0b want 0/0",
                   name, done[d], rd_valid[d]); err_cnt++;
        end
        @(negedge clk);
      end
      return;
    end

    beat = 0; cyc = 0; held = 0; got_done = 0; hd = '0; hl = 0;
    while (!got_done && cyc < 200) begin
      if (held) begin
        vec_cnt++;
        if (rd_valid[d] !== 1'b1 || rd_data[d] !== hd || rd_last[d] !== hl) begin
          $display("FAIL %s stall_hold: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                   name, rd_valid[d], rd_data[d], rd_last[d], hd, hl); err_cnt++;
        end
      end
      if (done[d] === 1'b1) begin
        got_done = 1;
        break;
      end
      if (rst_beat >= 0 && beat == rst_beat) begin
        rstN = 0;
        #1;
        vec_cnt++;
        if (rd_valid[d] !== 0 || rd_last[d] !== 0 || done[d] !== 0 || busy[d] !== 0 ||
            overrun[d] !== 0 || count[d] !== 0 || rd_data[d] !== 0) begin
          $display("FAIL %s reset_mid: got v=%0b l=%0b dn=%0b b=%0b o=%0b c=%0d d=%h want all 0",
                   name, rd_valid[d], rd_last[d], done[d], busy[d], overrun[d], count[d], rd_data[d]);
          err_cnt++;
        end
        rd_ready[d] = 0;
        @(negedge clk); rstN = 1;
        @(negedge clk);
        vec_cnt++;
        if (busy[d] !== 0 || done[d] !== 0 || rd_valid[d] !== 0) begin
          $display("FAIL %s reset_after: got b=%0b dn=%0b v=%0b want 0/0/0",
                   name, busy[d], done[d], rd_valid[d]); err_cnt++;
        end
        return;
      end
      case (ready_mode)
        0:       rdy = 1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      rd_ready[d] = rdy;
      arm[d] = arm_noise && ($urandom_range(0, 1) == 1);
      stop[d] = arm_noise && ($urandom_range(0, 1) == 1);
      if (rd_valid[d] === 1'b1) begin
        if (rdy) begin
          vec_cnt++;
          if (beat >= exp_q.size()) begin
            $display("FAIL %s extra_beat: got beat %0d data=%h want only %0d beats",
                     name, beat, rd_data[d], exp_q.size()); err_cnt++;
          end else if (rd_data[d] !== exp_q[beat] || rd_last[d] !== (beat == exp_q.size() - 1)) begin
            $display("FAIL %s beat%0d: got data=%h last=%0b want data=%h last=%0b",
                     name, beat, rd_data[d], rd_last[d], exp_q[beat], beat == exp_q.size() - 1);
            err_cnt++;
          end
          beat++; held = 0;
        end else begin
          held = 1; hd = rd_data[d]; hl = rd_last[d];
        end
      end else begin
        held = 0;
      end
      @(negedge clk);
      cyc++;
    end
    arm[d] = 0; stop[d] = 0; rd_ready[d] = 0;
    vec_cnt++;
    if (!got_done) begin
      $display("FAIL %s done_timeout: got no done after %0d cycles want done", name, cyc);
      err_cnt++;
      return;
    end
    if (beat !== exp_q.size() || rd_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
        count[d] !== 4'(exp_q.size()) || overrun[d] !== ovr) begin
      $display("FAIL %s done_state: got beats=%0d v=%0b b=%0b c=%0d o=%0b want beats=%0d v=0 b=0 c=%0d o=%0b",
               name, beat, rd_valid[d], busy[d], count[d], overrun[d],
               exp_q.size(), exp_q.size(), ovr);
      err_cnt++;
    end
`ifdef CAP_PEAK_DETECT_EN
    vec_cnt++;
    if (peak[d] !== pk) begin
      $display("FAIL %s peak: got %h want %h", name, peak[d], pk); err_cnt++;
    end
`endif
    @(negedge clk);
    vec_cnt++;
    if (done[d] !== 1'b0) begin
      $display("FAIL %s done_pulse: got done=%0b a cycle later want 0", name, done[d]); err_cnt++;
    end
  endtask

  task automatic clear_stim();
    stim_y.delete(); stim_v.delete(); stim_s.delete();
  endtask

  task automatic push(input logic [15:0] y, input bit v, input bit s);
    stim_y.push_back(y); stim_v.push_back(v); stim_s.push_back(s);
  endtask

  task automatic test_reset();
    rstN = 0;
    for (int d = 0; d < N; d++) begin
      arm[d] = 0; stop[d] = 0; y_valid[d] = 0; rd_ready[d] = 0; y_in[d] = '0;
    end
    #12;
    for (int d = 0; d < N; d++) begin
      vec_cnt++;
      if (rd_valid[d] !== 0 || rd_last[d] !== 0 || done[d] !== 0 || busy[d] !== 0 ||
          overrun[d] !== 0 || count[d] !== 0 || rd_data[d] !== 0) begin
        $display("FAIL reset dut%0d: got v=%0b l=%0b dn=%0b b=%0b o=%0b c=%0d d=%h want all 0",
                 d, rd_valid[d], rd_last[d], done[d], busy[d], overrun[d], count[d], rd_data[d]);
        err_cnt++;
      end
    end
    @(negedge clk); rstN = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_stim();
    for (int i = 1; i <= 8; i++) push(16'(i), 1, 0);
    run_case(0, "basic", 0, 0, -1);
  endtask

  task automatic test_pre_skip();
    clear_stim();
    for (int i = 10; i <= 20; i++) push(16'(i), 1, 0);
    run_case(1, "pre_skip", 0, 0, -1);
  endtask

  task automatic test_stop();
    clear_stim();
    push(-16'sd5, 1, 0); push(16'd7, 1, 0); push(-16'sd9, 1, 1);
    run_case(0, "stop_fill", 0, 0, -1);
  endtask

  task automatic test_stall();
    clear_stim();
    for (int i = 0; i < 5; i++) push(16'($urandom), 1, i == 4);
    run_case(0, "stall", 1, 0, -1);
  endtask

  task automatic test_overrun();
    clear_stim();
    for (int i = 0; i < 8; i++) push(16'($urandom), 1, 0);
    run_case(0, "overrun", 2, 2, -1);
    vec_cnt++;
    if (overrun[0] !== 1'b1) begin
      $display("FAIL overrun_sticky: got %0b want 1", overrun[0]); err_cnt++;
    end
    clear_stim();
    push(16'h1234, 0, 1);
    run_case(0, "stop_empty", 0, 0, -1);
    clear_stim();
    push(16'h0001, 1, 0); push(16'h0002, 1, 1);
    run_case(1, "stop_skip", 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    int len, d;
    arm_noise = 1;
    for (int it = 0; it < 16; it++) begin
      clear_stim();
      d = $urandom_range(0, 1);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++)
        push(16'($urandom), $urandom_range(0, 3) != 0, i == len - 1);
      run_case(d, $sformatf("rand%0d", it), 2, $urandom_range(0, 2), -1);
    end
    arm_noise = 0;
  endtask

  task automatic test_reset_mid();
    clear_stim();
    for (int i = 0; i < 6; i++) push(16'($urandom), 1, i == 5);
    run_case(0, "reset_mid", 0, 0, 2);
  endtask

`ifdef CAP_PEAK_DETECT_EN
  task automatic test_peak();
    clear_stim();
    push(16'h8000, 1, 0); push(16'd100, 1, 1);
    run_case(0, "peak", 0, 0, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_pre_skip();
    test_stop();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef CAP_PEAK_DETECT_EN
    test_peak();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
